// File: rtl/timer_core.sv
// Prescaled compare timer. It mirrors its control registers from an external register
// file by scanning them round-robin, and it writes COUNT, STATUS and CMD clears back.
module timer_core #(
    parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] rdaddr_perip,
    input  logic [31:0] data_o_perip,
    output logic [3:0]  be_perip,
    output logic        write_perip,
    output logic [31:0] wraddr_perip,
    output logic [31:0] data_i_perip,
    output logic        irq_o
);

    localparam logic [31:0] ADDR_PRE    = 32'h0000_0000;
    localparam logic [31:0] ADDR_CMP    = 32'h0000_0004;
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0008;
    localparam logic [31:0] ADDR_CMD    = 32'h0000_000C;
    localparam logic [31:0] ADDR_COUNT  = 32'h0000_0014;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0018;

    typedef enum logic [1:0] {
        PH_CTRL = 2'd0,
        PH_PRE  = 2'd1,
        PH_CMP  = 2'd2,
        PH_CMD  = 2'd3
    } phase_t;

    phase_t      r_phase;
    phase_t      w_phaseNext;

    logic [2:0]  r_ctrlSh;
    logic [31:0] r_preSh;
    logic [31:0] r_cmpSh;
    logic [31:0] r_pcnt;
    logic [31:0] r_cnt;
    logic        r_flag;
    logic        r_halt;
    logic        r_cmdPend;
    logic [1:0]  r_lastStatus;
    logic        r_write;
    logic [31:0] r_wrAddr;
    logic [31:0] r_wrData;
    logic        r_irq;

    logic        w_running;
    logic        w_tick;
    logic        w_match;
    logic        w_capCtrl;
    logic        w_capCmd;
    logic        w_clrFlag;
    logic        w_rstCnt;
    logic [1:0]  w_status;
    logic        w_statusWrite;
    logic [31:0] w_wrAddr;
    logic [31:0] w_wrData;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_phase <= PH_CTRL;
        end else begin
            r_phase <= w_phaseNext;
        end
    end

    always_comb begin
        w_phaseNext  = PH_CTRL;
        rdaddr_perip = ADDR_CTRL;
        case (r_phase)
            PH_CTRL: begin w_phaseNext = PH_PRE;  rdaddr_perip = ADDR_CTRL; end
            PH_PRE:  begin w_phaseNext = PH_CMP;  rdaddr_perip = ADDR_PRE;  end
            PH_CMP:  begin w_phaseNext = PH_CMD;  rdaddr_perip = ADDR_CMP;  end
            PH_CMD:  begin w_phaseNext = PH_CTRL; rdaddr_perip = ADDR_CMD;  end
            default: begin w_phaseNext = PH_CTRL; rdaddr_perip = ADDR_CTRL; end
        endcase
    end

    assign w_running = r_ctrlSh[0] & ~r_halt;
    assign w_tick    = w_running && (r_pcnt == r_preSh);
    assign w_match   = w_tick && (r_cnt == r_cmpSh);
    assign w_capCtrl = (r_phase == PH_CTRL);
    assign w_capCmd  = (r_phase == PH_CMD) && (data_o_perip != 32'd0);
    assign w_clrFlag = w_capCmd & data_o_perip[0];
    assign w_rstCnt  = w_capCmd & data_o_perip[1];
    assign w_status  = {w_running, r_flag};

    // The pending CMD clear always wins arbitration, so it lasts exactly one decision.
    always_comb begin
        w_statusWrite = 1'b0;
        w_wrAddr      = ADDR_COUNT;
        w_wrData      = r_cnt;
        if (r_cmdPend) begin
            w_wrAddr = ADDR_CMD;
            w_wrData = 32'd0;
        end else if (w_status != r_lastStatus) begin
            w_statusWrite = 1'b1;
            w_wrAddr      = ADDR_STATUS;
            w_wrData      = {30'd0, w_status};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ctrlSh     <= 3'd0;
            r_preSh      <= 32'd0;
            r_cmpSh      <= RESET_CMP;
            r_pcnt       <= 32'd0;
            r_cnt        <= 32'd0;
            r_flag       <= 1'b0;
            r_halt       <= 1'b0;
            r_cmdPend    <= 1'b0;
            r_lastStatus <= 2'd0;
            r_write      <= 1'b0;
            r_wrAddr     <= 32'd0;
            r_wrData     <= 32'd0;
            r_irq        <= 1'b0;
        end else begin
            if (w_capCtrl)           r_ctrlSh <= data_o_perip[2:0];
            if (r_phase == PH_PRE)   r_preSh  <= data_o_perip;
            if (r_phase == PH_CMP)   r_cmpSh  <= data_o_perip;

            if (w_rstCnt || w_tick) r_pcnt <= 32'd0;
            else if (w_running)     r_pcnt <= r_pcnt + 32'd1;

            if (w_rstCnt || w_match) r_cnt <= 32'd0;
            else if (w_tick)         r_cnt <= r_cnt + 32'd1;

            if (w_match)        r_flag <= 1'b1;
            else if (w_clrFlag) r_flag <= 1'b0;

            // Disabling through CTRL always releases a one-shot halt.
            if (w_capCtrl && !data_o_perip[0]) r_halt <= 1'b0;
            else if (w_match && r_ctrlSh[1])   r_halt <= 1'b1;

            if (w_capCmd)       r_cmdPend <= 1'b1;
            else if (r_cmdPend) r_cmdPend <= 1'b0;

            if (w_statusWrite) r_lastStatus <= w_status;

            r_write  <= 1'b1;
            r_wrAddr <= w_wrAddr;
            r_wrData <= w_wrData;
            r_irq    <= r_flag & r_ctrlSh[2];
        end
    end

    assign be_perip     = 4'hF;
    assign write_perip  = r_write;
    assign wraddr_perip = r_wrAddr;
    assign data_i_perip = r_wrData;
    assign irq_o        = r_irq;

endmodule

// File: doc/timer_core.md
TIMER_CORE -- requirements
Module: timer_core

Interface
REQ-001 Parameter: RESET_CMP, 32'hFFFF_FFFF, reset value of the compare shadow.
REQ-002 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_ni  in  1  reset, synchronous and active-low.
REQ-004 Port: rdaddr_perip  out  32  byte address of the register-file peripheral read port.
REQ-005 Port: data_o_perip  in  32  read data, combinational from rdaddr_perip/be_perip.
REQ-006 Port: be_perip  out  4  byte enables shared by read and write; held at 4'hF.
REQ-007 Port: write_perip  out  1  write strobe into the register file.
REQ-008 Port: wraddr_perip  out  32  write byte address.
REQ-009 Port: data_i_perip  out  32  write data.
REQ-010 Port: irq_o  out  1  interrupt, level, registered.

Function
REQ-011 Register map, byte addresses: 0x00 PRE (bus RW); 0x04 CMP (bus RW); 0x08 CTRL; 0x0C CMD; 0x14 COUNT (core-written); 0x18 STATUS (core-written).
REQ-012 CTRL bits: [0] EN; [1] ONESHOT; [2] IRQ_EN.
REQ-013 CMD bits: [0] CLR_FLAG; [1] RST_CNT. Both are bus write-1 bits cleared by the core.
REQ-014 STATUS bits: [0] FLAG; [1] RUNNING; [31:2] zero.
REQ-015 Scanner: a 2-bit phase counter increments every cycle and wraps 3->0.
- rdaddr_perip = 0x08, 0x00, 0x04, 0x0C for phases 0..3.
- data_o_perip is captured at the clock edge into the shadows ctrl_sh[2:0], pre_sh, cmp_sh, or is decoded as CMD.
REQ-016 Any register change is visible in its shadow no later than 4 cycles after the bus write lands.
REQ-017 RUNNING = ctrl_sh[0] & ~halt.
- While RUNNING: the prescale counter pcnt increments each cycle.
- When pcnt==pre_sh: pcnt<=0 and a one-cycle tick is asserted. PRE=0 therefore ticks every cycle.
REQ-018 On tick: if cnt==cmp_sh then cnt<=0 and FLAG<=1; otherwise cnt<=cnt+1, wrapping 0xFFFF_FFFF->0.
- Match is on equality only.
- Lowering CMP below cnt lets cnt run to wrap.
REQ-019 A match with ctrl_sh[1]=1 sets halt.
- halt clears when a CTRL capture has EN=0.
- Counting then resumes on the next CTRL capture with EN=1.
REQ-020 While not RUNNING: pcnt and cnt hold their values.
REQ-021 CMD capture with a nonzero value:
- CLR_FLAG clears FLAG.
- RST_CNT zeroes cnt and pcnt.
- A clear of CMD becomes pending.
- CMD capture of zero has no effect.
REQ-022 Same-cycle conflicts:
- match and CLR_FLAG: FLAG ends 1.
- tick and RST_CNT: cnt ends 0.
REQ-023 Write arbitration: one full-word write per cycle, chosen by priority.
- First: pending CMD clear (0x0C <- 0).
- Second: STATUS, if its value differs from the last STATUS written.
- Otherwise: COUNT (0x14 <- cnt).
- write_perip is 1 every cycle after reset.
REQ-024 write_perip, wraddr_perip and data_i_perip are registered. They present the decision made from the state of the preceding cycle.
REQ-025 A bus CMD write landing in the same cycle as the core's clear is preserved, because bus writes have priority in the register file. It is processed at the next CMD capture.
REQ-026 A bus CMD write landing between the CMD capture and the core's clear is lost. This is accepted behaviour.
REQ-027 irq_o = FLAG & ctrl_sh[2], registered. It asserts the cycle after FLAG sets.

Reset
REQ-028 While rst_ni=0 at the clock edge, the following values are set:
- phase=0.
- ctrl_sh=0, pre_sh=0, cmp_sh=RESET_CMP.
- pcnt=0, cnt=0, FLAG=0, halt=0.
- CMD-clear pending=0.
- last-written STATUS=0.
REQ-029 Output values during reset:
- write_perip=0, wraddr_perip=0, data_i_perip=0.
- irq_o=0.
- rdaddr_perip=0x08, be_perip=4'hF.
REQ-030 Reset asserted mid-count discards all progress. A pending CMD clear is dropped, and the leftover CMD is re-processed after reset.

Verification
REQ-031 Setup PRE=0, CMP=3, CTRL=0x5, then run 40 cycles. Required: COUNT writes cycle through 0,1,2,3,0; FLAG=1 at each wrap; irq_o=1 one cycle after the first match.
REQ-032 Setup PRE=2, CMP=1. Required: tick every 3 cycles; first match 6 cycles after RUNNING.
REQ-033 ONESHOT: CTRL=0x3, CMP=2. Required: after the match, cnt stays 0 and STATUS=0x1. Then write CTRL=0x0, then 0x3: counting resumes.
REQ-034 CMD: write CMD=0x3 while cnt=5 and FLAG=1. Required: cnt=0, FLAG=0, irq_o=0; 0x0C reads 0 within 6 cycles.
REQ-035 Conflict: match tick and CLR_FLAG capture in the same cycle. Required: FLAG=1 and STATUS written as 0x3.
REQ-036 Reset mid-run: rst_ni=0 for 1 cycle at cnt=7. Required: all outputs take their reset values; cnt restarts from 0; cmp_sh=0xFFFF_FFFF until the first CMP capture.
